tline_delay_bank: RTL and testbench

- Multi-channel, sample-clocked digital transmission-line emulator: the discrete-time counterpart of the lumped TLIN model.
- Each channel delays its sample stream by a programmable number of samples and scales it by a common attenuation gain.
- It sits between a sample source and a sink, with valid/ready flow control on both sides, and is used for mixed-signal co-simulation of line delay.

---
 rtl/tline_pkg.sv | 36 +++
 rtl/tline_delay_mem.sv | 61 ++++++
 rtl/tline_delay_bank.sv | 149 ++++++++++++++
 tb/tb_tline_delay_bank.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/tline_pkg.sv
// rtl/tline_pkg.sv - shared types and arithmetic helpers for the delay bank
// Contents:
//   state_e    : reconfiguration FSM states (RUN, DRAIN, LOAD)
//   gain_unity : unity gain code for a Q1.(gain_w-1) gain
//   sat_trunc  : reduces a scaled sample to data_w bits. With
//                TLINE_DELAY_BANK_SAT_EN defined it clamps to the signed range;
//                otherwise it keeps the low data_w bits (two's-complement wrap).
package tline_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    LOAD  = 2'd2
  } state_e;

  function automatic int gain_unity(input int gain_w);
    return 1 << (gain_w - 1);
  endfunction

  // Result is sign-correct in 64 bits; callers keep only the low data_w bits.
  function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] product,
                                                   input int data_w);
`ifdef TLINE_DELAY_BANK_SAT_EN
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_w - 1));
    if (product > hi) return hi;
    else if (product < lo) return lo;
    else return product;
`else
    return (product <<< (64 - data_w)) >>> (64 - data_w);
`endif
  endfunction

endpackage

// File: rtl/tline_delay_mem.sv
// rtl/tline_delay_mem.sv - circular sample buffer with write pointer and fill level
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (pointer/fill only)
//   clr        : restart the line (pointer and fill back to zero)
//   we, wdata  : write one sample vector at the write pointer
//   delay      : read distance behind the write pointer
//   rdata      : combinational read of buf[wr_ptr - delay] (pre-write contents)
//   primed     : fill >= delay, i.e. the read slot holds a real sample
module tline_delay_mem #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 64,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             we,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] delay,
  output logic [WIDTH-1:0] rdata,
  output logic             primed
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] fill_q, fill_d;
  logic [PTR_W-1:0] rd_idx;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    if (clr) begin
      wr_ptr_d = '0;
      fill_d   = '0;
    end else if (we) begin
      // DEPTH is a power of two, so the pointer wraps naturally.
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (fill_q != PTR_W'(DEPTH - 1)) fill_d = fill_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // Storage is intentionally not reset; primed masks stale entries.
  always_ff @(posedge clk) begin
    if (we) mem_q[wr_ptr_q] <= wdata;
  end

  assign rd_idx = wr_ptr_q - delay;
  assign rdata  = mem_q[rd_idx];
  assign primed = (fill_q >= delay);

endmodule

// File: rtl/tline_delay_bank.sv
// rtl/tline_delay_bank.sv - multi-channel sample delay line with common gain
// Optional feature macro: TLINE_DELAY_BANK_SAT_EN (saturate instead of wrap).
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   s_valid, s_ready, s_data   : input sample vector, channel i at [i*DATA_W +: DATA_W]
//   m_valid, m_ready, m_data   : delayed, scaled output vector (registered)
//   cfg_load, cfg_delay, cfg_gain : request a new delay/gain (applied after draining)
//   cfg_busy                   : reconfiguration in progress
module tline_delay_bank
  import tline_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 64,
  parameter int GAIN_W   = 12
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [CHANNELS*DATA_W-1:0]   s_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [CHANNELS*DATA_W-1:0]   m_data,
  input  logic                         cfg_load,
  input  logic [$clog2(DEPTH)-1:0]     cfg_delay,
  input  logic [GAIN_W-1:0]            cfg_gain,
  output logic                         cfg_busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int VEC_W = CHANNELS * DATA_W;
  localparam int P_W   = DATA_W + GAIN_W + 1;
  localparam logic [GAIN_W-1:0] GAIN_ONE = GAIN_W'(gain_unity(GAIN_W));

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   delay_q, delay_d;
  logic [GAIN_W-1:0]  gain_q, gain_d;
  logic [PTR_W-1:0]   sh_delay_q, sh_delay_d;
  logic [GAIN_W-1:0]  sh_gain_q, sh_gain_d;
  logic               m_valid_q, m_valid_d;
  logic [VEC_W-1:0]   m_data_q, m_data_d;

  logic               xfer;
  logic [VEC_W-1:0]   rdata;
  logic               primed;
  logic [VEC_W-1:0]   src;
  logic [VEC_W-1:0]   scaled;
  logic signed [P_W-1:0] prod;
  logic signed [63:0]    wide;

  // rst_n gating keeps s_ready low while the block is held in reset.
  assign s_ready  = rst_n && (state_q == RUN) && (!m_valid_q || m_ready);
  assign xfer     = s_valid && s_ready;
  assign cfg_busy = (state_q != RUN);
  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;

  tline_delay_mem #(
    .DEPTH (DEPTH),
    .WIDTH (VEC_W),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state_q == LOAD),
    .we     (xfer),
    .wdata  (s_data),
    .delay  (delay_q),
    .rdata  (rdata),
    .primed (primed)
  );

  // Zero delay bypasses the buffer; an unprimed slot models an uncharged line.
  assign src = (delay_q == '0) ? s_data : (primed ? rdata : '0);

  always_comb begin
    scaled = '0;
    prod   = '0;
    wide   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      prod = $signed(src[i*DATA_W +: DATA_W]) * $signed({1'b0, gain_q});
      wide = 64'(prod >>> (GAIN_W - 1));
      scaled[i*DATA_W +: DATA_W] = DATA_W'(sat_trunc(wide, DATA_W));
    end
  end

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    if (xfer) begin
      m_valid_d = 1'b1;
      m_data_d  = scaled;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    delay_d    = delay_q;
    gain_d     = gain_q;
    sh_delay_d = sh_delay_q;
    sh_gain_d  = sh_gain_q;
    case (state_q)
      RUN: begin
        if (cfg_load) begin
          sh_delay_d = cfg_delay;
          sh_gain_d  = cfg_gain;
          state_d    = DRAIN;
        end
      end
      DRAIN: begin
        if (cfg_load) begin
          sh_delay_d = cfg_delay;
          sh_gain_d  = cfg_gain;
        end
        if (!m_valid_q || m_ready) state_d = LOAD;
      end
      LOAD: begin
        delay_d = sh_delay_q;
        gain_d  = sh_gain_q;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      delay_q    <= '0;
      gain_q     <= GAIN_ONE;
      sh_delay_q <= '0;
      sh_gain_q  <= GAIN_ONE;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
    end else begin
      state_q    <= state_d;
      delay_q    <= delay_d;
      gain_q     <= gain_d;
      sh_delay_q <= sh_delay_d;
      sh_gain_q  <= sh_gain_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
    end
  end

endmodule

// File: tb/tb_tline_delay_bank.sv
// tb/tb_tline_delay_bank.sv - scoreboard bench for tline_delay_bank
module tb_tline_delay_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [63:0] m_data;
  logic        cfg_load;
  logic [5:0]  cfg_delay;
  logic [11:0] cfg_gain;
  logic        cfg_busy;

  logic [63:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tline_delay_bank dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .cfg_load  (cfg_load),
    .cfg_delay (cfg_delay),
    .cfg_gain  (cfg_gain),
    .cfg_busy  (cfg_busy)
  );

  function automatic logic [63:0] mk(input int a, input int b, input int c, input int d);
    return {d[15:0], c[15:0], b[15:0], a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: an output handshake completes at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", m_data, 64'hx);
      end else begin
        chk("out_data", m_data, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] v, input logic [63:0] e);
    int n;
    s_valid = 1'b1;
    s_data  = v;
    exp_q.push_back(e);
    n = 0;
    while (1) begin
      @(negedge clk);
      if (s_ready) break;
      n++;
      if (n > 50) begin
        chk("send_accept", s_ready, 1);
        break;
      end
    end
    step();
    s_valid = 1'b0;
  endtask

  task automatic do_cfg(input logic [5:0] d, input logic [11:0] g);
    int n;
    cfg_load  = 1'b1;
    cfg_delay = d;
    cfg_gain  = g;
    step();
    cfg_load = 1'b0;
    n = 0;
    while (cfg_busy && n < 50) begin
      n++;
      step();
    end
    chk("cfg_done", cfg_busy, 0);
    chk("cfg_busy_cycles_ge2", (n >= 2), 1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      n++;
      step();
    end
    chk("scoreboard_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    cfg_load = 1'b0; cfg_delay = '0; cfg_gain = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_cfg_busy", cfg_busy, 0);
    rst_n = 1'b1;
    step();
    chk("post_rst_s_ready", s_ready, 1);

    // Bypass, unity gain, one-cycle latency.
    for (int k = 1; k <= 3; k++) begin
      send(mk(k, k, k, k), mk(k, k, k, k));
      chk("lat_valid", m_valid, 1);
      chk("lat_data", m_data, mk(k, k, k, k));
    end
    wait_drain();

    // Delay of 3: first three outputs come from an uncharged line.
    do_cfg(6'd3, 12'h800);
    for (int k = 1; k <= 5; k++) begin
      logic [63:0] e;
      if (k <= 3) e = '0;
      else e = mk((k - 3) * 10, (k - 3) * 10 + 1, -(k - 3) * 10, 0);
      send(mk(k * 10, k * 10 + 1, -k * 10, 0), e);
    end
    wait_drain();

    // Half gain, floor rounding of the arithmetic shift.
    do_cfg(6'd0, 12'h400);
    send(mk(-7, 7, -1, 100), mk(-4, 3, -1, 50));
    wait_drain();

    // Near-double gain overflow.
    do_cfg(6'd0, 12'hFFF);
`ifdef TLINE_DELAY_BANK_SAT_EN
    send(mk(32767, -32768, 1, 0), mk(32767, -32768, 1, 0));
`else
    send(mk(32767, -32768, 1, 0), mk(-18, 16, 1, 0));
`endif
    wait_drain();

    // Backpressure: output held, input stalled, nothing lost or duplicated.
    do_cfg(6'd0, 12'h800);
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = mk(111, 112, 113, 114);
    exp_q.push_back(mk(111, 112, 113, 114));
    step();
    chk("bp_first_valid", m_valid, 1);
    s_data = mk(221, 222, 223, 224);
    for (int c = 0; c < 5; c++) begin
      chk("bp_s_ready_low", s_ready, 0);
      chk("bp_m_data_hold", m_data, mk(111, 112, 113, 114));
      step();
    end
    exp_q.push_back(mk(221, 222, 223, 224));
    m_ready = 1'b1;
    step();
    s_valid = 1'b0;
    wait_drain();

    // Two back-to-back reconfigurations behind a pending output.
    m_ready = 1'b0;
    send(mk(7, 8, 9, 10), mk(7, 8, 9, 10));
    cfg_load = 1'b1; cfg_delay = 6'd5; cfg_gain = 12'h800;
    step();
    cfg_delay = 6'd2;
    step();
    cfg_load = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("drain_busy", cfg_busy, 1);
      chk("drain_pending", m_valid, 1);
      step();
    end
    m_ready = 1'b1;
    begin
      int n;
      n = 0;
      while (cfg_busy && n < 50) begin
        n++;
        step();
      end
      chk("drain_done", cfg_busy, 0);
    end
    for (int k = 1; k <= 4; k++) begin
      logic [63:0] e;
      if (k <= 2) e = '0;
      else e = mk(1000 + k - 2, 2000 + k - 2, -(k - 2), 5);
      send(mk(1000 + k, 2000 + k, -k, 5), e);
    end
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
